// File: rtl/money_change.sv
// money_change: latches credit/price on start and pays out credit - price greedily as
// 10/5/1-yuan coin commands, one coin per coin_ack handshake. Define MONEY_CHANGE_TIMEOUT_EN
// to add the coin_ack timeout (TIMEOUT cycles) that raises fault.
module money_change #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [4:0] credit,
   input  logic [4:0] price,
   input  logic       coin_ack,
   output logic       out10,
   output logic       out5,
   output logic       out1,
   output logic [4:0] remain,
   output logic       busy,
   output logic       done,
   output logic       short,
   output logic       fault
);

   typedef enum logic [1:0] {StIdle, StCheck, StWait, StDone} state_e;

   state_e     state_q, state_d;
   logic [2:0] coin_q, coin_d;  // {out10, out5, out1}
   logic [4:0] remain_q, remain_d;
   logic       short_q, short_d;
   logic [4:0] denom;

   if (TIMEOUT == 0) begin : g_timeout_check
      $error("money_change: TIMEOUT must be at least 1");
   end

`ifdef MONEY_CHANGE_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   localparam logic [CntW:0] Limit = (CntW + 1)'(TIMEOUT);
   localparam logic [CntW:0] One = (CntW + 1)'(1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            fault_q, fault_d;
   logic            expired;

   // Counts completed WAIT cycles; the current one would be the TIMEOUT-th without an ack.
   assign expired = ({1'b0, cnt_q} + One) >= Limit;
`endif

   always_comb begin
      case (coin_q)
         3'b100:  denom = 5'd10;
         3'b010:  denom = 5'd5;
         3'b001:  denom = 5'd1;
         default: denom = 5'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      coin_d   = coin_q;
      remain_d = remain_q;
      short_d  = short_q;
`ifdef MONEY_CHANGE_TIMEOUT_EN
      cnt_d    = cnt_q;
      fault_d  = fault_q;
`endif
      case (state_q)
         StIdle: begin
            if (start) begin
               short_d  = credit < price;
               remain_d = (credit < price) ? 5'd0 : credit - price;
`ifdef MONEY_CHANGE_TIMEOUT_EN
               fault_d  = 1'b0;
`endif
               state_d  = StCheck;
            end
         end
         StCheck: begin
            if (short_q || remain_q == 5'd0) begin
               state_d = StDone;
            end else begin
               if (remain_q >= 5'd10) begin
                  coin_d = 3'b100;
               end else if (remain_q >= 5'd5) begin
                  coin_d = 3'b010;
               end else begin
                  coin_d = 3'b001;
               end
`ifdef MONEY_CHANGE_TIMEOUT_EN
               cnt_d   = '0;
`endif
               state_d = StWait;
            end
         end
         StWait: begin
            if (coin_ack) begin
               coin_d   = 3'b000;
               remain_d = remain_q - denom;
               state_d  = StCheck;
            end
`ifdef MONEY_CHANGE_TIMEOUT_EN
            else if (expired) begin
               // Unpaid amount stays visible on remain.
               coin_d  = 3'b000;
               fault_d = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            coin_d  = 3'b000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         coin_q   <= 3'b000;
         remain_q <= 5'd0;
         short_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         coin_q   <= coin_d;
         remain_q <= remain_d;
         short_q  <= short_d;
      end
   end

`ifdef MONEY_CHANGE_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign out10  = coin_q[2];
   assign out5   = coin_q[1];
   assign out1   = coin_q[0];
   assign remain = remain_q;
   assign short  = short_q;
   assign busy   = (state_q != StIdle);
   assign done   = (state_q == StDone);

endmodule

// File: tb/tb_money_change.sv
// Scoreboard bench for money_change: the driver pushes expected coin/done events derived
// from credit/price arithmetic; a monitor pops and checks them as the DUT presents them.
module tb_money_change;

   typedef struct {
      int kind;  // 10, 5 or 1 for a coin command, 0 for the done pulse
      int rem;
      bit shrt;
      bit flt;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [4:0] credit;
   logic [4:0] price;
   logic       coin_ack;
   logic       out10, out5, out1;
   logic [4:0] remain;
   logic       busy, done, short, fault;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  cyc = 0;
   int  ref_cyc = 0;

`ifdef MONEY_CHANGE_TIMEOUT_EN
   money_change #(.TIMEOUT(4)) dut (
`else
   money_change dut (
`endif
      .clk(clk), .reset(reset), .start(start), .credit(credit), .price(price),
      .coin_ack(coin_ack), .out10(out10), .out5(out5), .out1(out1), .remain(remain),
      .busy(busy), .done(done), .short(short), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference model: greedy change from plain arithmetic.
   task automatic push_txn(input int cr, input int pr);
      int   c;
      ev_t  e;
      c = (cr >= pr) ? cr - pr : 0;
      for (int i = 0; i < c / 10; i++) begin
         e = '{10, c - 10 * i, 1'b0, 1'b0}; exp_q.push_back(e);
      end
      for (int i = 0; i < (c % 10) / 5; i++) begin
         e = '{5, c % 10, 1'b0, 1'b0}; exp_q.push_back(e);
      end
      for (int i = 0; i < c % 5; i++) begin
         e = '{1, (c % 5) - i, 1'b0, 1'b0}; exp_q.push_back(e);
      end
      e = '{0, 0, (cr < pr), 1'b0};
      exp_q.push_back(e);
   endtask

   function automatic int ncoins(input int cr, input int pr);
      int c;
      c = (cr >= pr) ? cr - pr : 0;
      return c / 10 + (c % 10) / 5 + c % 5;
   endfunction

   // Monitor: every event must appear one edge after the start/ack edge that caused it.
   initial begin
      logic [2:0] prev, cur;
      ev_t        e;
      int         kind;
      prev = 3'b000;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         cur = {out10, out5, out1};
         if (reset) begin
            prev = 3'b000;
         end else begin
            chk("coin_onehot", int'($countones(cur) <= 1), 1);
            if (cur != 3'b000 && prev == 3'b000) begin
               kind = out10 ? 10 : (out5 ? 5 : 1);
               if (exp_q.size() == 0) begin
                  chk("unexpected_coin", kind, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("coin_denom", kind, e.kind);
                  chk("coin_remain", int'(remain), e.rem);
                  chk("coin_time", cyc, ref_cyc + 1);
               end
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("done_kind", 0, e.kind);
                  chk("done_short", int'(short), int'(e.shrt));
                  chk("done_remain", int'(remain), e.rem);
                  chk("done_fault", int'(fault), int'(e.flt));
                  chk("done_time", cyc, ref_cyc + 1);
                  chk("done_busy", int'(busy), 1);
                  chk("done_coins_low", int'(cur), 0);
               end
            end
            prev = cur;
         end
      end
   end

   task automatic wait_coin(output bit ok);
      int t;
      t = 0;
      while ((out10 | out5 | out1) == 1'b0 && t < 50) begin
         @(negedge clk);
         coin_ack = 1'b0;
         start = 1'b0;
         t++;
      end
      ok = (t < 50);
      if (!ok) chk("coin_wait_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 100) begin
         @(negedge clk);
         coin_ack = 1'b0;
         start = 1'b0;
         t++;
      end
      chk("idle_wait", int'(busy), 0);
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic run_txn(input int cr, input int pr, input bit noise);
      bit ok;
      int d;
      push_txn(cr, pr);
      @(negedge clk);
      start = 1'b1; credit = 5'(cr); price = 5'(pr);
      ref_cyc = cyc + 1;
      @(negedge clk);
      // A start while busy must be ignored.
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      credit = 5'($urandom_range(0, 31)); price = 5'($urandom_range(0, 31));
      for (int i = 0; i < ncoins(cr, pr); i++) begin
         wait_coin(ok);
         if (!ok) break;
         d = noise ? $urandom_range(0, 3) : 1;
         coin_ack = 1'b0;
         start = 1'b0;
         repeat (d) @(negedge clk);
         coin_ack = 1'b1;
         ref_cyc = cyc + 1;
         @(negedge clk);
         // This ack lands while the DUT is checking and must be ignored.
         coin_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      wait_idle();
   endtask

   task automatic reset_mid();
      bit  ok;
      ev_t e;
      e = '{10, 20, 1'b0, 1'b0}; exp_q.push_back(e);
      e = '{10, 10, 1'b0, 1'b0}; exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1; credit = 5'd20; price = 5'd0;
      ref_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      wait_coin(ok);
      coin_ack = 1'b1;
      ref_cyc = cyc + 1;
      @(negedge clk);
      coin_ack = 1'b0;
      wait_coin(ok);
      reset = 1'b1;
      #1;
      chk("rst_mid_coins", int'({out10, out5, out1}), 0);
      chk("rst_mid_remain", int'(remain), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_flags", int'({done, short, fault}), 0);
      chk("rst_mid_queue", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      run_txn(9, 2, 1'b0);
   endtask

`ifdef MONEY_CHANGE_TIMEOUT_EN
   task automatic timeout_txn();
      bit  ok;
      int  hi;
      ev_t e;
      e = '{5, 6, 1'b0, 1'b0}; exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1; credit = 5'd6; price = 5'd0;
      ref_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      wait_coin(ok);
      hi = 0;
      while (out5 && hi < 20) begin
         hi++;
         @(negedge clk);
      end
      chk("timeout_coin_cycles", hi, 4);
      e = '{0, 6, 1'b0, 1'b1}; exp_q.push_back(e);
      ref_cyc = cyc - 1;  // done follows the expiry edge by one edge
      wait_idle();
      chk("timeout_fault_held", int'(fault), 1);
   endtask
`endif

   initial begin
      int cr, pr;
      reset = 1'b1; start = 1'b0; coin_ack = 1'b0; credit = 5'd0; price = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_coins", int'({out10, out5, out1}), 0);
      chk("reset_remain", int'(remain), 0);
      chk("reset_flags", int'({busy, done, short, fault}), 0);
      @(negedge clk);
      reset = 1'b0;

      run_txn(17, 0, 1'b0);
      run_txn(8, 3, 1'b0);
      run_txn(3, 5, 1'b0);
      chk("short_held", int'(short), 1);
      run_txn(12, 12, 1'b1);
      chk("short_cleared", int'(short), 0);
      run_txn(31, 0, 1'b0);
      run_txn(0, 0, 1'b1);
      run_txn(0, 31, 1'b1);
      reset_mid();
`ifdef MONEY_CHANGE_TIMEOUT_EN
      timeout_txn();
      run_txn(7, 1, 1'b0);
      chk("fault_cleared", int'(fault), 0);
`endif

      for (int n = 0; n < 150; n++) begin
         cr = $urandom_range(0, 31);
         pr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, cr);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_txn(cr, pr, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/money_change.md
# money_change

Change-dispensing controller for the vending datapath, at the output end of the coin-accumulation path. On a start pulse it latches the accumulated credit and item price, computes change = credit − price, and pays it out greedily as 10/5/1-yuan coin commands to the payout mechanism, one coin per `coin_ack` handshake. It reports shortfall when credit < price and pulses `done` when the transaction closes.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles to wait for `coin_ack` before faulting (used only with `MONEY_CHANGE_TIMEOUT_EN`).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: begin transaction; sampled only in IDLE.
- `credit` input 5: accumulated credit, 0..31 yuan; latched with `start`.
- `price` input 5: item price, 0..31 yuan; latched with `start`.
- `coin_ack` input 1: payout mechanism has released the commanded coin.
- `out10`, `out5`, `out1` output 1 each: coin command, registered, at most one high.
- `remain` output 5: change still owed (registered).
- `busy` output 1: high in any state except IDLE.
- `done` output 1: one-cycle pulse at transaction end.
- `short` output 1: credit < price for the last transaction; held until next accepted `start`.
- `fault` output 1: ack timeout (always 0 without the macro); held until next accepted `start`.

## Operation
- States: IDLE, CHECK, WAIT, DONE.
- IDLE: on `start`=1, `remain` <= credit − price (5-bit), `short` <= (credit < price), `fault` <= 0, go CHECK. Otherwise stay.
- CHECK: if `short` or `remain`==0, go DONE. Else select denomination: remain ≥ 10 → `out10`; else ≥ 5 → `out5`; else `out1`; set that output, go WAIT.
- WAIT: hold coin output. On `coin_ack`=1: clear coin output, `remain` <= remain − denom, go CHECK.
- DONE: `done`=1 (decoded from state), go IDLE.
- If `short`, `remain` is forced to 0 instead of the wrapped difference; no coins issued.
- `coin_ack` ignored outside WAIT. `start` ignored outside IDLE.
- Reset (any time, including mid-payout): state IDLE, all coin outputs 0, `remain`=0, `busy`=0, `done`=0, `short`=0, `fault`=0. Partially paid change is abandoned.

## Timing
- `start` sampled at edge k → CHECK after k; first coin output high after edge k+1.
- `coin_ack` sampled at edge m → coin output low and `remain` updated after m; next coin high after m+1 (minimum one low cycle between coins).
- `coin_ack` high in the same cycle the coin rises counts (ack at the first edge in WAIT).
- Zero change or shortfall: `done` high in cycle k+2, `busy` low from k+3.
- Last ack at edge m → `done` high after m+1 for one cycle.
- Maximum coins per transaction: 31 → 10,10,10,1.

## Configuration
- `MONEY_CHANGE_TIMEOUT_EN` defined: an 8+-bit wait counter clears on entry to WAIT; if `TIMEOUT` cycles elapse in WAIT without `coin_ack`, clear coin output, set `fault`=1, go DONE (`remain` keeps unpaid amount).
- Not defined: no counter; WAIT waits indefinitely; `fault` tied to 0.

## Test plan
- credit=17, price=0, ack one cycle after each coin → out10, out5, out1, out1 in order; `remain` 17→7→2→1→0; one `done` pulse.
- credit=8, price=3 → single `out5`; `remain` 5→0; `done`; `short`=0.
- credit=3, price=5 → no coin outputs; `short`=1, `remain`=0, `done` in cycle k+2.
- credit=price=12 → no coins, `done` in cycle k+2, `short`=0; `start` pulsed while busy in a second transaction is ignored.
- credit=20, price=0, assert `reset` while `out10` high awaiting second ack → all outputs 0 immediately, state IDLE, subsequent `start` works normally.
- With `MONEY_CHANGE_TIMEOUT_EN`, TIMEOUT=4, credit=6, price=0, never ack → `out5` high 4 cycles then low, `fault`=1, `remain`=6, `done` pulse.
